// File: rtl/ep2_arb_pkg.sv
// ep2_arb_pkg: shared types and constants for the event round-robin arbiter.
// Used by event_rr_arbiter and its sub-modules.
package ep2_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_e;

    localparam int STAT_W = 32;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; finds the first set request
// strictly after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/event_rr_arbiter.sv
// event_rr_arbiter: atomic round-robin merge of context + buffer event streams.
// Optional per-source grant counters are built when ARB_STATS_EN is defined.
module event_rr_arbiter
    import ep2_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int CTX_W   = 160,
    parameter int DATA_W  = 512,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*CTX_W-1:0]  s_ctx_tdata,
    input  logic [NUM_SRC-1:0]        s_ctx_tvalid,
    output logic [NUM_SRC-1:0]        s_ctx_tready,
    input  logic [NUM_SRC*DATA_W-1:0] s_buf_tdata,
    input  logic [NUM_SRC*KEEP_W-1:0] s_buf_tkeep,
    input  logic [NUM_SRC-1:0]        s_buf_tlast,
    input  logic [NUM_SRC-1:0]        s_buf_tvalid,
    output logic [NUM_SRC-1:0]        s_buf_tready,
    output logic [CTX_W-1:0]          m_ctx_tdata,
    output logic                      m_ctx_tvalid,
    input  logic                      m_ctx_tready,
    output logic [DATA_W-1:0]         m_buf_tdata,
    output logic [KEEP_W-1:0]         m_buf_tkeep,
    output logic                      m_buf_tlast,
    output logic                      m_buf_tvalid,
    input  logic                      m_buf_tready,
    output logic [ID_W-1:0]           m_grant_id,
    output logic                      m_busy
`ifdef ARB_STATS_EN
    ,
    input  logic                      stat_clear,
    output logic [NUM_SRC*STAT_W-1:0] stat_grant_cnt
`endif
);

    arb_state_e      state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] pick_idx;
    logic            pick_found;
    logic            ctx_done;
    logic            buf_done;
    logic            busy;
    logic            ctx_hs;
    logic            buf_fin;
    logic            xfer_exit;

    rr_pick #(
        .N  (NUM_SRC),
        .IW (ID_W)
    ) u_pick (
        .req   (s_ctx_tvalid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign busy       = (state == ARB_XFER);
    assign m_busy     = busy;
    assign m_grant_id = grant;

    assign m_ctx_tdata = s_ctx_tdata[int'(grant)*CTX_W +: CTX_W];
    assign m_buf_tdata = s_buf_tdata[int'(grant)*DATA_W +: DATA_W];
    assign m_buf_tkeep = s_buf_tkeep[int'(grant)*KEEP_W +: KEEP_W];
    assign m_buf_tlast = s_buf_tlast[grant];

    assign m_ctx_tvalid = busy & s_ctx_tvalid[grant] & ~ctx_done;
    assign m_buf_tvalid = busy & s_buf_tvalid[grant] & ~buf_done;

    assign ctx_hs  = m_ctx_tvalid & m_ctx_tready;
    assign buf_fin = m_buf_tvalid & m_buf_tready & m_buf_tlast;

    // Leave as soon as both halves of the event are (or are becoming) done.
    assign xfer_exit = busy
                     & (ctx_done | ctx_hs)
                     & (buf_done | buf_fin);

    always_comb begin
        s_ctx_tready = '0;
        s_buf_tready = '0;
        if (busy) begin
            s_ctx_tready[grant] = m_ctx_tready & ~ctx_done;
            s_buf_tready[grant] = m_buf_tready & ~buf_done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            ptr      <= ID_W'(NUM_SRC - 1);
            grant    <= '0;
            ctx_done <= 1'b0;
            buf_done <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant <= pick_idx;
                        state <= ARB_XFER;
                    end
                end
                ARB_XFER: begin
                    if (xfer_exit) begin
                        ptr      <= grant;
                        ctx_done <= 1'b0;
                        buf_done <= 1'b0;
                        state    <= ARB_IDLE;
                    end else begin
                        if (ctx_hs) begin
                            ctx_done <= 1'b1;
                        end
                        if (buf_fin) begin
                            buf_done <= 1'b1;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_stat
        logic [STAT_W-1:0] cnt;

        // Clear has priority over a coincident increment.
        always_ff @(posedge clk) begin
            if (rst || stat_clear) begin
                cnt <= '0;
            end else if (xfer_exit && grant == ID_W'(i) && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stat_grant_cnt[i*STAT_W +: STAT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_event_rr_arbiter.sv
// tb_event_rr_arbiter: scoreboard bench for event_rr_arbiter.
// Directed events per source; a negedge monitor pops expected beats on handshakes.
module tb_event_rr_arbiter;

    localparam int NS = 4;
    localparam int CW = 16;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NS*CW-1:0] s_ctx_tdata = '0;
    logic [NS-1:0]   s_ctx_tvalid = '0;
    logic [NS-1:0]   s_ctx_tready;
    logic [NS*DW-1:0] s_buf_tdata = '0;
    logic [NS*KW-1:0] s_buf_tkeep = '0;
    logic [NS-1:0]   s_buf_tlast = '0;
    logic [NS-1:0]   s_buf_tvalid = '0;
    logic [NS-1:0]   s_buf_tready;
    logic [CW-1:0]   m_ctx_tdata;
    logic            m_ctx_tvalid;
    logic            m_ctx_tready = 1'b1;
    logic [DW-1:0]   m_buf_tdata;
    logic [KW-1:0]   m_buf_tkeep;
    logic            m_buf_tlast;
    logic            m_buf_tvalid;
    logic            m_buf_tready = 1'b1;
    logic [IW-1:0]   m_grant_id;
    logic            m_busy;
`ifdef ARB_STATS_EN
    logic            stat_clear = 1'b0;
    logic [NS*32-1:0] stat_grant_cnt;
`endif

    event_rr_arbiter #(
        .NUM_SRC (NS),
        .CTX_W   (CW),
        .DATA_W  (DW),
        .KEEP_W  (KW),
        .ID_W    (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_ctx_tdata  (s_ctx_tdata),
        .s_ctx_tvalid (s_ctx_tvalid),
        .s_ctx_tready (s_ctx_tready),
        .s_buf_tdata  (s_buf_tdata),
        .s_buf_tkeep  (s_buf_tkeep),
        .s_buf_tlast  (s_buf_tlast),
        .s_buf_tvalid (s_buf_tvalid),
        .s_buf_tready (s_buf_tready),
        .m_ctx_tdata  (m_ctx_tdata),
        .m_ctx_tvalid (m_ctx_tvalid),
        .m_ctx_tready (m_ctx_tready),
        .m_buf_tdata  (m_buf_tdata),
        .m_buf_tkeep  (m_buf_tkeep),
        .m_buf_tlast  (m_buf_tlast),
        .m_buf_tvalid (m_buf_tvalid),
        .m_buf_tready (m_buf_tready),
        .m_grant_id   (m_grant_id),
        .m_busy       (m_busy)
`ifdef ARB_STATS_EN
        ,
        .stat_clear     (stat_clear),
        .stat_grant_cnt (stat_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Source model: per-source ctx words and buffer beats with head/tail.
    logic [CW-1:0] cmem [NS][8];
    beat_t         bmem [NS][16];
    logic [3:0]    chead [NS];
    logic [3:0]    ctail [NS];
    logic [4:0]    bhead [NS];
    logic [4:0]    btail [NS];
    logic [NS-1:0] chs = '0;
    logic [NS-1:0] bhs = '0;
    logic          tog = 1'b0;
    logic          buf_rdy = 1'b1;

    logic [IW+CW-1:0]   exp_c [$];
    logic [IW+DW+KW:0]  exp_b [$];
    int                 hs_cyc [$];
    int                 cyc = 0;
    int                 buf_hs_cnt = 0;
    int                 n_chk = 0;
    int                 n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            chead[i] = '0;
            ctail[i] = '0;
            bhead[i] = '0;
            btail[i] = '0;
        end
    endtask

    task automatic add_event(input int s, input logic [CW-1:0] word,
                             input int n, input logic [KW-1:0] lkeep,
                             input bit push);
        beat_t b;
        cmem[s][ctail[s][2:0]] = word;
        ctail[s]++;
        if (push) exp_c.push_back({IW'(s), word});
        for (int k = 0; k < n; k++) begin
            b.data = {8'(s), word[7:0], 8'h00, 8'(k)};
            b.last = (k == n - 1);
            b.keep = b.last ? lkeep : 4'hF;
            bmem[s][btail[s][3:0]] = b;
            btail[s]++;
            if (push) exp_b.push_back({IW'(s), b});
        end
    endtask

    // Driver: advance on last cycle's handshakes, then present the heads.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NS; i++) begin
            if (chs[i]) chead[i]++;
            if (bhs[i]) bhead[i]++;
            s_ctx_tvalid[i] = (chead[i] < ctail[i]);
            s_ctx_tdata[i*CW +: CW] = cmem[i][chead[i][2:0]];
            s_buf_tvalid[i] = (bhead[i] < btail[i]);
            s_buf_tdata[i*DW +: DW] = bmem[i][bhead[i][3:0]].data;
            s_buf_tkeep[i*KW +: KW] = bmem[i][bhead[i][3:0]].keep;
            s_buf_tlast[i] = bmem[i][bhead[i][3:0]].last;
        end
        m_buf_tready = tog ? ~m_buf_tready : buf_rdy;
    end

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        chs = s_ctx_tvalid & s_ctx_tready;
        bhs = s_buf_tvalid & s_buf_tready;
        if (!rst) begin
            if (m_ctx_tvalid && m_ctx_tready) begin
                hs_cyc.push_back(cyc);
                if (exp_c.size() == 0)
                    check("ctx_unexpected", 64'(m_ctx_tdata), 64'hDEAD);
                else
                    check("ctx", 64'({m_grant_id, m_ctx_tdata}),
                          64'(exp_c.pop_front()));
            end
            if (m_buf_tvalid && m_buf_tready) begin
                buf_hs_cnt++;
                if (exp_b.size() == 0)
                    check("buf_unexpected", 64'(m_buf_tdata), 64'hDEAD);
                else
                    check("buf", 64'({m_grant_id, m_buf_tdata,
                                      m_buf_tkeep, m_buf_tlast}),
                          64'(exp_b.pop_front()));
            end
            if (!m_busy)
                check("idle_quiet", 64'({s_ctx_tready, s_buf_tready,
                                         m_ctx_tvalid, m_buf_tvalid}), 0);
            else
                check("grant_excl",
                      64'((s_ctx_tready | s_buf_tready) &
                          ~(NS'(1) << m_grant_id)), 0);
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_ctx_tready = 1'b1;
        buf_rdy = 1'b1;
        tog = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic wait_busy(input int budget);
        bit ok = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            step();
            if (m_busy) ok = 1;
        end
        check("wait_busy_timeout", 64'(ok), 1);
    endtask

    task automatic wait_drain(input int budget);
        bit ok = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            step();
            if (exp_c.size() == 0 && exp_b.size() == 0 && !m_busy) ok = 1;
        end
        check("drain_timeout", 64'(ok), 1);
    endtask

    initial begin
        int base;
        bit ok;

        // Reset state
        do_reset();
        check("rst_busy", 64'(m_busy), 0);
        check("rst_grant", 64'(m_grant_id), 0);
        check("rst_mvalid", 64'({m_ctx_tvalid, m_buf_tvalid}), 0);
        check("rst_sready", 64'({s_ctx_tready, s_buf_tready}), 0);

        // Src0 and src2 together: src0 first, 1-cycle grant latency
        add_event(0, 16'hA0A0, 2, 4'h3, 1);
        add_event(2, 16'hC2C2, 2, 4'h1, 1);
        step();
        check("lat_before", 64'(m_ctx_tvalid), 0);
        step();
        check("lat_one", 64'(m_ctx_tvalid), 1);
        check("first_busy", 64'(m_busy), 1);
        check("first_grant", 64'(m_grant_id), 0);
        wait_drain(40);

        // All four with 1-beat events: order 0,1,2,3,0 with one bubble
        do_reset();
        hs_cyc.delete();
        add_event(0, 16'h0010, 1, 4'h1, 1);
        add_event(1, 16'h0111, 1, 4'h3, 1);
        add_event(2, 16'h0212, 1, 4'h7, 1);
        add_event(3, 16'h0313, 1, 4'hF, 1);
        add_event(0, 16'h0020, 1, 4'h1, 1);
        wait_drain(60);
        check("rr_count", 64'(hs_cyc.size()), 5);
        if (hs_cyc.size() == 5)
            for (int k = 1; k < 5; k++)
                check("rr_bubble", 64'(hs_cyc[k] - hs_cyc[k-1]), 2);

        // Src1 3 beats with ctx held off until 2 cycles after beat 3
        do_reset();
        m_ctx_tready = 1'b0;
        base = buf_hs_cnt;
        add_event(1, 16'h1111, 3, 4'h7, 1);
        wait_busy(10);
        check("dly_grant", 64'(m_grant_id), 1);
        add_event(2, 16'h2222, 1, 4'h1, 1);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            step();
            if (buf_hs_cnt - base >= 3) ok = 1;
        end
        check("dly_beats", 64'(ok), 1);
        for (int k = 0; k < 2; k++) begin
            check("dly_busy", 64'(m_busy), 1);
            check("dly_hold_grant", 64'(m_grant_id), 1);
            check("dly_buf_quiet", 64'({m_buf_tvalid, s_buf_tready}), 0);
            check("dly_ctx_rdy", 64'(s_ctx_tready), 0);
            step();
        end
        m_ctx_tready = 1'b1;
        wait_drain(40);

        // 5-beat packet with m_buf_tready toggling
        do_reset();
        tog = 1'b1;
        base = buf_hs_cnt;
        add_event(2, 16'h5252, 5, 4'h3, 1);
        wait_drain(60);
        check("tog_beats", 64'(buf_hs_cnt - base), 5);
        tog = 1'b0;

        // Reset on the second XFER cycle, then pointer restarts at source 0
        do_reset();
        add_event(0, 16'h0A0A, 1, 4'hF, 1);
        wait_drain(20);
        m_ctx_tready = 1'b0;
        buf_rdy = 1'b0;
        add_event(1, 16'h1B1B, 4, 4'hF, 0);
        wait_busy(10);
        step();
        rst = 1'b1;
        model_reset();
        step();
        check("mid_rst_busy", 64'(m_busy), 0);
        check("mid_rst_mvalid", 64'({m_ctx_tvalid, m_buf_tvalid}), 0);
        check("mid_rst_sready", 64'({s_ctx_tready, s_buf_tready}), 0);
        rst = 1'b0;
        m_ctx_tready = 1'b1;
        buf_rdy = 1'b1;
        add_event(0, 16'h0C0C, 1, 4'h1, 1);
        add_event(2, 16'h2C2C, 1, 4'h1, 1);
        wait_drain(40);

`ifdef ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++)
            add_event(3, 16'h3300 + 16'(k), 1, 4'hF, 1);
        wait_drain(60);
        check("stat_src3", 64'(stat_grant_cnt[3*32 +: 32]), 3);
        check("stat_src0", 64'(stat_grant_cnt[0 +: 32]), 0);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        check("stat_clear", 64'(stat_grant_cnt[3*32 +: 32]), 0);
`endif

        check("sb_ctx_left", 64'(exp_c.size()), 0);
        check("sb_buf_left", 64'(exp_b.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
